// File: rtl/sram_like_axi_bridge_if.sv
// Bus bundle between the CPU's two sram-like ports and a single AXI3 master.
// The "master" modport is the bridge's view; "slave" is the CPU/interconnect side.
interface sram_like_axi_bridge_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_like_axi_bridge.sv
// Merges the CPU inst (read-only) and data (read/write) sram-like ports onto one
// single-beat AXI3 master with one read and one write outstanding.
module sram_like_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic                          clk,
    input  logic                          reset,
    sram_like_axi_bridge_if.master        bus
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    rstate_t     r_rstate;
    rstate_t     w_rnext;
    wstate_t     r_wstate;
    wstate_t     w_wnext;

    logic [31:0] r_araddr;
    logic [3:0]  r_arid;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_rd_holds_data;
    logic        w_wr_accept;
    logic        w_rd_slot_free;
    logic        w_data_rd_accept;
    logic        w_inst_accept;
    logic        w_r_hs;
    logic        w_b_hs;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_unused_inputs;

    // A data read in flight blocks writes so data_data_ok stays in acceptance order.
    assign w_rd_holds_data  = (r_rstate != R_IDLE) && (r_arid != ID_INST);
    assign w_wr_accept      = (r_wstate == W_IDLE) && bus.data_req && bus.data_wr && !w_rd_holds_data;
    // Reads never start while a write is pending or being accepted.
    assign w_rd_slot_free   = (r_rstate == R_IDLE) && (r_wstate == W_IDLE) && !w_wr_accept;
    assign w_data_rd_accept = w_rd_slot_free && bus.data_req && !bus.data_wr;
    assign w_inst_accept    = w_rd_slot_free && bus.inst_req && !(bus.data_req && !bus.data_wr);

    assign w_r_hs   = (r_rstate == R_DATA) && bus.rvalid;
    assign w_b_hs   = (r_wstate == W_RESP) && bus.bvalid;
    assign w_aw_fin = r_aw_done || bus.awready;
    assign w_w_fin  = r_w_done || bus.wready;

    // Read FSM next-state decode
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_data_rd_accept || w_inst_accept) w_rnext = R_AR;
                else                                   w_rnext = R_IDLE;
            end
            R_AR: begin
                if (bus.arready) w_rnext = R_DATA;
                else             w_rnext = R_AR;
            end
            R_DATA: begin
                if (bus.rvalid) w_rnext = R_IDLE;
                else            w_rnext = R_DATA;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // Write FSM next-state decode
    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_wr_accept) w_wnext = W_REQ;
                else             w_wnext = W_IDLE;
            end
            W_REQ: begin
                if (w_aw_fin && w_w_fin) w_wnext = W_RESP;
                else                     w_wnext = W_REQ;
            end
            W_RESP: begin
                if (bus.bvalid) w_wnext = W_IDLE;
                else            w_wnext = W_RESP;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // Read FSM state and AR payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_araddr <= 32'd0;
            r_arid   <= 4'd0;
        end else begin
            r_rstate <= w_rnext;
            if (w_data_rd_accept) begin
                r_araddr <= bus.data_addr;
                r_arid   <= ID_DATA;
            end else if (w_inst_accept) begin
                r_araddr <= bus.inst_addr;
                r_arid   <= ID_INST;
            end
        end
    end

    // Write FSM state, AW/W payload and per-channel completion flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_wstate  <= w_wnext;
            r_aw_done <= (r_wstate == W_REQ) ? w_aw_fin : 1'b0;
            r_w_done  <= (r_wstate == W_REQ) ? w_w_fin : 1'b0;
            if (w_wr_accept) begin
                r_awaddr <= bus.data_addr;
                r_wdata  <= bus.data_wdata;
                r_wstrb  <= bus.data_wstrb;
            end
        end
    end

    assign bus.inst_addr_ok = w_inst_accept;
    assign bus.data_addr_ok = w_data_rd_accept || w_wr_accept;
    assign bus.inst_data_ok = w_r_hs && (bus.rid == ID_INST);
    assign bus.data_data_ok = (w_r_hs && (bus.rid != ID_INST)) || w_b_hs;
    assign bus.inst_rdata   = bus.rdata;
    assign bus.data_rdata   = bus.rdata;

    assign bus.arid    = r_arid;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = 4'd0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'd0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = (r_rstate == R_AR);
    assign bus.rready  = (r_rstate == R_DATA);

    assign bus.awid    = ID_DATA;
    assign bus.awaddr  = r_awaddr;
    assign bus.awlen   = 4'd0;
    assign bus.awsize  = 3'b010;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'd0;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = (r_wstate == W_REQ) && !r_aw_done;

    assign bus.wid     = ID_DATA;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = (r_wstate == W_REQ) && !r_w_done;
    assign bus.bready  = (r_wstate == W_RESP);

    assign w_unused_inputs = ^{bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed bench: table of single transactions plus hand-written multi-cycle
// sequences for arbitration, ordering, split AW/W handshakes and reset.
module tb_sram_like_axi_bridge;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    sram_like_axi_bridge_if bus ();

    sram_like_axi_bridge #(
        .ID_INST (4'd0),
        .ID_DATA (4'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic        inst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [3:0]  exp_id;
        logic        exp_inst_ok;
        logic        exp_data_ok;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'd0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        bus.arready    = 1'b0;
        bus.rid        = 4'd0;
        bus.rdata      = 32'd0;
        bus.rresp      = 2'd0;
        bus.rlast      = 1'b1;
        bus.rvalid     = 1'b0;
        bus.awready    = 1'b0;
        bus.wready     = 1'b0;
        bus.bid        = 4'd0;
        bus.bresp      = 2'd0;
        bus.bvalid     = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_valids"}, {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'd0);
        chk({name, "_oks"}, {28'd0, bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
    endtask

    // One complete transaction with zero-latency AXI responses.
    task automatic run_vec(input vec_t v);
        clear_inputs();
        if (v.inst) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = v.addr;
        end else begin
            bus.data_req   = 1'b1;
            bus.data_wr    = v.wr;
            bus.data_addr  = v.addr;
            bus.data_wdata = v.wdata;
            bus.data_wstrb = v.wstrb;
        end
        @(negedge clk);
        chk({v.name, "_inst_addr_ok"}, {31'd0, bus.inst_addr_ok}, {31'd0, v.inst});
        chk({v.name, "_data_addr_ok"}, {31'd0, bus.data_addr_ok}, {31'd0, !v.inst});
        tick();
        clear_inputs();
        if (v.wr) begin
            bus.awready = 1'b1;
            bus.wready  = 1'b1;
        end else begin
            bus.arready = 1'b1;
        end
        @(negedge clk);
        if (v.wr) begin
            chk({v.name, "_aw_w_valid"}, {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
            chk({v.name, "_awaddr"}, bus.awaddr, v.addr);
            chk({v.name, "_wdata"}, bus.wdata, v.wdata);
            chk({v.name, "_wstrb_ids"}, {20'd0, bus.wstrb, bus.awid, bus.wid}, {20'd0, v.wstrb, v.exp_id, v.exp_id});
        end else begin
            chk({v.name, "_arvalid"}, {31'd0, bus.arvalid}, 32'd1);
            chk({v.name, "_araddr"}, bus.araddr, v.addr);
            chk({v.name, "_arid"}, {28'd0, bus.arid}, {28'd0, v.exp_id});
        end
        tick();
        clear_inputs();
        if (v.wr) begin
            bus.bvalid = 1'b1;
        end else begin
            bus.rvalid = 1'b1;
            bus.rid    = v.exp_id;
            bus.rdata  = v.rdata;
        end
        @(negedge clk);
        chk({v.name, "_resp_ready"}, {30'd0, bus.rready, bus.bready}, v.wr ? 32'd1 : 32'd2);
        chk({v.name, "_data_oks"}, {30'd0, bus.inst_data_ok, bus.data_data_ok},
            {30'd0, v.exp_inst_ok, v.exp_data_ok});
        if (!v.wr) begin
            chk({v.name, "_rdata"}, v.inst ? bus.inst_rdata : bus.data_rdata, v.rdata);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        chk_quiet({v.name, "_after"});
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{"inst_rd_boot", 1'b0, 1'b1, 32'h1C00_0000, 32'h0, 4'h0, 32'h0280_0C0C, 4'd0, 1'b1, 1'b0};
        vecs[1] = '{"data_rd_80",   1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h1234_5678, 4'd1, 1'b0, 1'b1};
        vecs[2] = '{"data_wr_100",  1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0, 4'd1, 1'b0, 1'b1};
        vecs[3] = '{"data_wr_full", 1'b1, 1'b0, 32'h2000_0004, 32'hA5A5_5A5A, 4'b1111, 32'h0, 4'd1, 1'b0, 1'b1};
        vecs[4] = '{"inst_rd_bfc",  1'b0, 1'b1, 32'hBFC0_0000, 32'h3C08_BFC0, 4'h0, 32'h3C08_BFC0, 4'd0, 1'b1, 1'b0};

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_payload", bus.araddr | bus.awaddr | bus.wdata | {24'd0, bus.wstrb, bus.arid}, 32'd0);
        chk("const_fields", {bus.arlen, bus.arsize, bus.arburst, bus.awlen, bus.awsize, bus.awburst,
            bus.wlast, bus.arlock, bus.arcache, bus.arprot},
            {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1, 2'd0, 4'd0, 3'd0});
        tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Data read beats a simultaneous inst read; inst retries afterwards.
        clear_inputs();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0040;
        bus.data_req = 1'b1; bus.data_addr = 32'h0000_0080;
        @(negedge clk);
        chk("arb_oks", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd1);
        tick();
        bus.data_req = 1'b0; bus.arready = 1'b1;
        @(negedge clk);
        chk("arb_inst_wait_ar", {31'd0, bus.inst_addr_ok}, 32'd0);
        chk("arb_ar", {bus.araddr[27:0], bus.arid}, {28'h000_0080, 4'd1});
        tick();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("arb_data_done", {29'd0, bus.inst_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 32'd1);
        chk("arb_data_rdata", bus.data_rdata, 32'hCAFE_F00D);
        tick();
        bus.rvalid = 1'b0;
        @(negedge clk);
        chk("arb_inst_retry_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 1'b0; bus.arready = 1'b1;
        @(negedge clk);
        chk("arb_inst_ar", {bus.araddr, bus.arid}, {32'h1C00_0040, 4'd0});
        tick();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h1111_2222;
        @(negedge clk);
        chk("arb_inst_done", {bus.inst_rdata[30:0], bus.inst_data_ok}, {31'h1111_2222, 1'b1});
        tick();
        clear_inputs();

        // W handshakes three cycles before AW; bready only after both.
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h100;
        bus.data_wdata = 32'hDEAD_BEEF; bus.data_wstrb = 4'b0011;
        @(negedge clk);
        chk("split_accept", {31'd0, bus.data_addr_ok}, 32'd1);
        tick();
        clear_inputs(); bus.wready = 1'b1;
        @(negedge clk);
        chk("split_both_valid", {29'd0, bus.awvalid, bus.wvalid, bus.bready}, 32'b110);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.wready  = 1'b0;
            bus.awready = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("split_aw_held", {29'd0, bus.awvalid, bus.wvalid, bus.bready}, 32'b100);
            chk("split_aw_payload", bus.awaddr ^ bus.wdata, 32'h100 ^ 32'hDEAD_BEEF);
            tick();
        end
        bus.awready = 1'b0;
        @(negedge clk);
        chk("split_bready", {28'd0, bus.awvalid, bus.wvalid, bus.bready, bus.data_data_ok}, 32'b0010);
        tick();
        bus.bvalid = 1'b1;
        @(negedge clk);
        chk("split_bresp_ok", {31'd0, bus.data_data_ok}, 32'd1);
        tick();
        bus.bvalid = 1'b0;
        @(negedge clk);
        chk_quiet("split_after");
        tick();

        // Write accepted over inst read; inst blocked through a slow B response.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0080;
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h200;
        bus.data_wdata = 32'h0BAD_CAFE; bus.data_wstrb = 4'b1111;
        @(negedge clk);
        chk("wfirst_oks", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd1);
        tick();
        bus.data_req = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
        @(negedge clk);
        chk("wfirst_inst_blk_req", {31'd0, bus.inst_addr_ok}, 32'd0);
        tick();
        bus.awready = 1'b0; bus.wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wfirst_inst_blk_resp", {30'd0, bus.inst_addr_ok, bus.bready}, 32'd1);
            tick();
        end
        bus.bvalid = 1'b1;
        @(negedge clk);
        chk("wfirst_bvalid", {30'd0, bus.inst_addr_ok, bus.data_data_ok}, 32'd1);
        tick();
        bus.bvalid = 1'b0;
        @(negedge clk);
        chk("wfirst_inst_now_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 1'b0; bus.arready = 1'b1;
        @(negedge clk);
        chk("wfirst_inst_ar", bus.araddr, 32'h1C00_0080);
        tick();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h4444_5555;
        @(negedge clk);
        chk("wfirst_inst_done", {31'd0, bus.inst_data_ok}, 32'd1);
        tick();
        clear_inputs();

        // Inst read and data write completing in the same cycle.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_00C0;
        @(negedge clk);
        chk("dual_inst_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 1'b0; bus.arready = 1'b1;
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h300;
        bus.data_wdata = 32'h55AA_55AA; bus.data_wstrb = 4'b1000;
        @(negedge clk);
        chk("dual_wr_during_inst", {31'd0, bus.data_addr_ok}, 32'd1);
        tick();
        clear_inputs(); bus.awready = 1'b1; bus.wready = 1'b1;
        @(negedge clk);
        chk("dual_aw_w_r", {29'd0, bus.awvalid, bus.wvalid, bus.rready}, 32'b111);
        tick();
        clear_inputs();
        bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h7777_8888; bus.bvalid = 1'b1;
        @(negedge clk);
        chk("dual_both_ok", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd3);
        chk("dual_inst_rdata", bus.inst_rdata, 32'h7777_8888);
        tick();
        clear_inputs();
        @(negedge clk);
        chk_quiet("dual_after");
        tick();

        // Back-to-back data read then write: the write waits for the read.
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h90;
        @(negedge clk);
        chk("b2b_rd_accept", {31'd0, bus.data_addr_ok}, 32'd1);
        tick();
        bus.data_wr = 1'b1; bus.data_addr = 32'h94; bus.data_wdata = 32'h0102_0304;
        bus.data_wstrb = 4'b1111; bus.arready = 1'b1;
        @(negedge clk);
        chk("b2b_wr_held_ar", {31'd0, bus.data_addr_ok}, 32'd0);
        tick();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h9090_9090;
        @(negedge clk);
        chk("b2b_rd_done", {30'd0, bus.data_addr_ok, bus.data_data_ok}, 32'd1);
        chk("b2b_rd_rdata", bus.data_rdata, 32'h9090_9090);
        tick();
        bus.rvalid = 1'b0;
        @(negedge clk);
        chk("b2b_wr_accept", {30'd0, bus.data_addr_ok, bus.data_data_ok}, 32'd2);
        tick();
        bus.data_req = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
        @(negedge clk);
        chk("b2b_wr_payload", bus.awaddr ^ bus.wdata, 32'h94 ^ 32'h0102_0304);
        tick();
        clear_inputs(); bus.bvalid = 1'b1;
        @(negedge clk);
        chk("b2b_wr_done", {31'd0, bus.data_data_ok}, 32'd1);
        tick();
        clear_inputs();

        // Reset while waiting for R data abandons the read.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0100;
        @(negedge clk);
        chk("rst_inst_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 1'b0; bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        @(negedge clk);
        chk("rst_in_rdata", {31'd0, bus.rready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("rst_after");
        chk("rst_araddr", bus.araddr, 32'd0);
        tick();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0200;
        @(negedge clk);
        chk("rst_idle_accept", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
